crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_stream_engine_if.sv | 36 +++
 rtl/crc_stream_engine.sv | 120 ++++++++++++
 tb/tb_crc_stream_engine.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/crc_stream_engine_if.sv
// crc_stream_engine_if
// Bundles the beat stream, the result stream and the error flag of the CRC
// stream engine.
//   crc_initial : seed for a frame, taken on the sop beat
//   s_*         : input beat stream (valid/ready, data, sop, last)
//   m_*         : result stream (valid/ready, crc, beat count)
//   err_pulse   : one-cycle protocol-error flag
// Modport "slave" is the engine side; modport "master" is the side that
// feeds beats and consumes results.
interface crc_stream_engine_if #(
  parameter int CRC_WIDTH  = 4,
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 8
);
  logic [CRC_WIDTH-1:0]  crc_initial;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_sop;
  logic                  s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [CRC_WIDTH-1:0]  m_crc;
  logic [CNT_WIDTH-1:0]  m_len;
  logic                  err_pulse;

  modport slave (
    input  crc_initial, s_valid, s_data, s_sop, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_len, err_pulse
  );

  modport master (
    output crc_initial, s_valid, s_data, s_sop, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_len, err_pulse
  );
endinterface

// File: rtl/crc_stream_engine.sv
// crc_stream_engine
// Computes a non-augmented, MSB-first CRC over a framed stream of beats and
// presents the final CRC and the frame length as a held result.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : crc_stream_engine_if.slave (beat input, result output, err_pulse)
module crc_stream_engine #(
  parameter int                   CRC_WIDTH  = 4,
  parameter int                   DATA_WIDTH = 5,
  parameter logic [CRC_WIDTH-1:0] POLY       = 4'b0011,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '0,
  parameter int                   CNT_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  crc_stream_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CRC_WIDTH-1:0]  crc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  m_valid_q;
  logic [CRC_WIDTH-1:0]  m_crc_q;
  logic [CNT_WIDTH-1:0]  m_len_q;
  logic                  err_q;

  logic                  ready;
  logic                  beat;
  logic                  take;
  logic                  bad;
  logic [CRC_WIDTH-1:0]  crc_next;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // Runs the per-bit LFSR update over a whole beat, MSB first.
  function automatic logic [CRC_WIDTH-1:0] crc_step(
    input logic [CRC_WIDTH-1:0]  seed,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = seed;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ data[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // Ready is forced low while reset is held so nothing transfers then.
  assign ready    = !rst && (state_q != HOLD);
  assign beat     = bus.s_valid && ready;
  // A beat is used when it starts a frame or continues one; a stray
  // non-sop beat in IDLE is dropped.
  assign take     = beat && (bus.s_sop || (state_q == CALC));
  assign bad      = beat && (((state_q == IDLE) && !bus.s_sop) ||
                             ((state_q == CALC) && bus.s_sop));
  assign crc_next = crc_step(bus.s_sop ? bus.crc_initial : crc_q, bus.s_data);
  assign cnt_next = bus.s_sop ? CNT_WIDTH'(1) :
                    ((cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a sop beat seen in CALC simply restarts the frame,
  // so CALC only needs to look at last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (take) state_d = bus.s_last ? HOLD : CALC;
      CALC: if (take && bus.s_last) state_d = HOLD;
      HOLD: if (m_valid_q && bus.m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: running CRC, beat counter, held result and error flag. The
  // result registers only load on a last beat, which cannot arrive in HOLD,
  // so they stay stable while m_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_crc_q   <= '0;
      m_len_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= bad;
      if (take) begin
        crc_q <= crc_next;
        cnt_q <= cnt_next;
        if (bus.s_last) begin
          m_crc_q   <= crc_next ^ XOR_OUT;
          m_len_q   <= cnt_next;
          m_valid_q <= 1'b1;
        end
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready   = ready;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_crc     = m_crc_q;
  assign bus.m_len     = m_len_q;
  assign bus.err_pulse = err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine
// Directed bench for crc_stream_engine: default-parameter instance plus a
// second instance with XOR_OUT = 4'b1111. Expected CRCs are hand-computed
// for POLY = x^4+x+1, 5-bit beats, MSB first.
module tb_crc_stream_engine;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  crc_stream_engine_if #(.CRC_WIDTH(4), .DATA_WIDTH(5), .CNT_WIDTH(8)) bus ();
  crc_stream_engine_if #(.CRC_WIDTH(4), .DATA_WIDTH(5), .CNT_WIDTH(8)) bus2 ();

  crc_stream_engine #(
    .CRC_WIDTH(4), .DATA_WIDTH(5), .POLY(4'b0011), .XOR_OUT(4'b0000), .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  crc_stream_engine #(
    .CRC_WIDTH(4), .DATA_WIDTH(5), .POLY(4'b0011), .XOR_OUT(4'b1111), .CNT_WIDTH(8)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  // Presents one beat for a single clock; returns 1 ns after that edge.
  task automatic applyStimulus(input logic [3:0] seed, input logic [4:0] data,
                               input logic sop, input logic last);
    bus.crc_initial = seed;
    bus.s_data      = data;
    bus.s_sop       = sop;
    bus.s_last      = last;
    bus.s_valid     = 1'b1;
    @(posedge clk); #1;
    bus.s_valid     = 1'b0;
    bus.s_sop       = 1'b0;
    bus.s_last      = 1'b0;
  endtask

  // Accepts the held result and checks the return to IDLE.
  task automatic releaseResult(input string tag);
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    checkOutput({tag, "_mvalid_clr"}, 32'(bus.m_valid), 32'd0);
    checkOutput({tag, "_sready_idle"}, 32'(bus.s_ready), 32'd1);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    bus.crc_initial = '0; bus.s_valid = 1'b0; bus.s_data = '0;
    bus.s_sop = 1'b0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    bus2.crc_initial = '0; bus2.s_valid = 1'b0; bus2.s_data = '0;
    bus2.s_sop = 1'b0; bus2.s_last = 1'b0; bus2.m_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_mvalid", 32'(bus.m_valid), 32'd0);
    checkOutput("rst_mcrc",   32'(bus.m_crc),   32'd0);
    checkOutput("rst_mlen",   32'(bus.m_len),   32'd0);
    checkOutput("rst_err",    32'(bus.err_pulse), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_sready", 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;

    // Single sop+last beat, seed 0000, 10101 -> 1010, len 1.
    applyStimulus(4'b0000, 5'b10101, 1'b1, 1'b1);
    checkOutput("one_mvalid", 32'(bus.m_valid), 32'd1);
    checkOutput("one_mcrc",   32'(bus.m_crc),   32'b1010);
    checkOutput("one_mlen",   32'(bus.m_len),   32'd1);
    checkOutput("one_sready", 32'(bus.s_ready), 32'd0);
    releaseResult("one");

    // Two beats: 10101 then 00000 -> 1001, len 2, latency one clock.
    applyStimulus(4'b0000, 5'b10101, 1'b1, 1'b0);
    checkOutput("two_mvalid_early", 32'(bus.m_valid), 32'd0);
    checkOutput("two_sready_calc",  32'(bus.s_ready), 32'd1);
    applyStimulus(4'b0000, 5'b00000, 1'b0, 1'b1);
    checkOutput("two_mvalid", 32'(bus.m_valid), 32'd1);
    checkOutput("two_mcrc",   32'(bus.m_crc),   32'b1001);
    checkOutput("two_mlen",   32'(bus.m_len),   32'd2);
    releaseResult("two");

    // Seed 1111, beat 00000 -> 0100.
    applyStimulus(4'b1111, 5'b00000, 1'b1, 1'b1);
    checkOutput("seed_mcrc", 32'(bus.m_crc), 32'b0100);
    checkOutput("seed_mlen", 32'(bus.m_len), 32'd1);
    releaseResult("seed");

    // Seed 0101, beat 11111 -> 1010.
    applyStimulus(4'b0101, 5'b11111, 1'b1, 1'b1);
    checkOutput("ones_mcrc", 32'(bus.m_crc), 32'b1010);
    releaseResult("ones");

    // Back-pressure: HOLD for 5 cycles with s_valid high.
    applyStimulus(4'b0000, 5'b10101, 1'b1, 1'b1);
    bus.s_valid = 1'b1; bus.s_sop = 1'b1; bus.s_last = 1'b1; bus.s_data = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_sready_%0d", i), 32'(bus.s_ready), 32'd0);
      checkOutput($sformatf("hold_mvalid_%0d", i), 32'(bus.m_valid), 32'd1);
      checkOutput($sformatf("hold_mcrc_%0d", i),   32'(bus.m_crc),   32'b1010);
      checkOutput($sformatf("hold_mlen_%0d", i),   32'(bus.m_len),   32'd1);
    end
    bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_last = 1'b0;
    releaseResult("hold");

    // Stray non-sop beat in IDLE.
    applyStimulus(4'b0000, 5'b10101, 1'b0, 1'b0);
    checkOutput("stray_err",    32'(bus.err_pulse), 32'd1);
    checkOutput("stray_mvalid", 32'(bus.m_valid),   32'd0);
    checkOutput("stray_sready", 32'(bus.s_ready),   32'd1);
    @(posedge clk); #1;
    checkOutput("stray_err_clr", 32'(bus.err_pulse), 32'd0);

    // sop mid-frame restarts: result must match the fresh 2-beat frame.
    applyStimulus(4'b0000, 5'b11111, 1'b1, 1'b0);
    checkOutput("abort_err_none", 32'(bus.err_pulse), 32'd0);
    applyStimulus(4'b0000, 5'b10101, 1'b1, 1'b0);
    checkOutput("abort_err", 32'(bus.err_pulse), 32'd1);
    applyStimulus(4'b0000, 5'b00000, 1'b0, 1'b1);
    checkOutput("abort_err_clr", 32'(bus.err_pulse), 32'd0);
    checkOutput("abort_mcrc",    32'(bus.m_crc),     32'b1001);
    checkOutput("abort_mlen",    32'(bus.m_len),     32'd2);
    releaseResult("abort");

    // Reset in the cycle after the sop beat of a 3-beat frame.
    applyStimulus(4'b0000, 5'b11111, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_sready", 32'(bus.s_ready),   32'd0);
    checkOutput("midrst_mvalid", 32'(bus.m_valid),   32'd0);
    checkOutput("midrst_mcrc",   32'(bus.m_crc),     32'd0);
    checkOutput("midrst_mlen",   32'(bus.m_len),     32'd0);
    checkOutput("midrst_err",    32'(bus.err_pulse), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_mvalid", 32'(bus.m_valid), 32'd0);

    // Clean 3-beat frame: 11111, 00001, 10000 -> 1001, len 3.
    applyStimulus(4'b0000, 5'b11111, 1'b1, 1'b0);
    applyStimulus(4'b0000, 5'b00001, 1'b0, 1'b0);
    checkOutput("three_mvalid_early", 32'(bus.m_valid), 32'd0);
    applyStimulus(4'b0000, 5'b10000, 1'b0, 1'b1);
    checkOutput("three_mvalid", 32'(bus.m_valid), 32'd1);
    checkOutput("three_mcrc",   32'(bus.m_crc),   32'b1001);
    checkOutput("three_mlen",   32'(bus.m_len),   32'd3);
    releaseResult("three");

    // 300 zero beats: length saturates at 255, CRC stays 0.
    bus.crc_initial = 4'b0000;
    bus.s_data      = 5'b00000;
    bus.s_valid     = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.s_sop  = (i == 0);
      bus.s_last = (i == 299);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0; bus.s_sop = 1'b0; bus.s_last = 1'b0;
    checkOutput("sat_mvalid", 32'(bus.m_valid), 32'd1);
    checkOutput("sat_mlen",   32'(bus.m_len),   32'd255);
    checkOutput("sat_mcrc",   32'(bus.m_crc),   32'd0);
    releaseResult("sat");

    // XOR_OUT = 1111 instance: seed 1111, beat 00000 -> 0100 ^ 1111 = 1011.
    bus2.crc_initial = 4'b1111;
    bus2.s_data      = 5'b00000;
    bus2.s_sop       = 1'b1;
    bus2.s_last      = 1'b1;
    bus2.s_valid     = 1'b1;
    @(posedge clk); #1;
    bus2.s_valid = 1'b0;
    checkOutput("xor_mvalid", 32'(bus2.m_valid), 32'd1);
    checkOutput("xor_mcrc",   32'(bus2.m_crc),   32'b1011);
    checkOutput("xor_mlen",   32'(bus2.m_len),   32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
